mem_stage_sram_ctrl: RTL and testbench

- Responder side of the execute-to-memory interface of the 5-stage ARM pipeline.
- Accepts load/store requests carrying a computed address (`alu_result`), store data (`val_rm`), writeback control and destination register.
- Performs each 32-bit access as two 16-bit transactions on an external asynchronous SRAM, with a configurable number of wait cycles per transaction.
- Holds `ready` low while busy so the hazard/freeze logic stalls all earlier stages.

---
 rtl/mem_stage_sram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage responder for the 5-stage ARM pipeline.
// Performs each 32-bit load/store as two 16-bit accesses on an external
// asynchronous SRAM, freezing earlier stages via ready while busy.
module mem_stage_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        val_rm_in,
  input  logic [3:0]         dest_in,

  output logic               wb_en,
  output logic               mem_r_en,
  output logic [31:0]        alu_result,
  output logic [3:0]         dest,
  output logic [31:0]        mem_data,
  output logic               ready,

  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned   CntW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrLo,
    StWrHi,
    StRdLo,
    StRdHi,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     mem_data_q, mem_data_d;

  // Pipeline control signals pass straight through, independent of state.
  assign wb_en      = wb_en_in;
  assign mem_r_en   = mem_r_en_in;
  assign alu_result = alu_result_in;
  assign dest       = dest_in;
  assign mem_data   = mem_data_q;

  // Byte address -> 16-bit SRAM location; addresses below the base simply wrap.
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word_idx;
  logic [SRAM_AW-1:0] addr_lo, addr_hi;
  logic               unused_offset_bits;

  assign offset             = alu_result_in - 32'(BASE_ADDR);
  assign word_idx           = offset[SRAM_AW:2];
  assign addr_lo            = {word_idx, 1'b0};
  assign addr_hi            = {word_idx, 1'b1};
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  logic last_wait;
  assign last_wait = (cnt_q == CntLast);

  // Next-state logic: sequencing, wait counting and read-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    mem_data_d = mem_data_q;
    case (state_q)
      StIdle: begin
        // A store wins when both enables are set.
        if (mem_w_en_in) begin
          state_d = StWrLo;
        end else if (mem_r_en_in) begin
          state_d = StRdLo;
        end
      end
      StWrLo: begin
        if (last_wait) state_d = StWrHi;
        else           cnt_d   = cnt_q + CntW'(1);
      end
      StWrHi: begin
        if (last_wait) state_d = StDone;
        else           cnt_d   = cnt_q + CntW'(1);
      end
      StRdLo: begin
        if (last_wait) begin
          mem_data_d[15:0] = sram_rdata;
          state_d          = StRdHi;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdHi: begin
        if (last_wait) begin
          mem_data_d[31:16] = sram_rdata;
          state_d           = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      // The still-held request is not restarted; the pipeline advances here.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // SRAM strobes, address and write data decoded from the current state.
  always_comb begin
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      StWrLo: begin
        sram_we_n  = 1'b0;
        sram_addr  = addr_lo;
        sram_wdata = val_rm_in[15:0];
      end
      StWrHi: begin
        sram_we_n  = 1'b0;
        sram_addr  = addr_hi;
        sram_wdata = val_rm_in[31:16];
      end
      StRdLo: begin
        sram_oe_n = 1'b0;
        sram_addr = addr_lo;
      end
      StRdHi: begin
        sram_oe_n = 1'b0;
        sram_addr = addr_hi;
      end
      default: ;
    endcase
  end

  // ready drops in the very cycle a request appears in idle.
  always_comb begin
    ready = 1'b0;
    if (state_q == StDone) begin
      ready = 1'b1;
    end else if (state_q == StIdle && !mem_w_en_in && !mem_r_en_in) begin
      ready = 1'b1;
    end
  end

  // State, wait counter and load-result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_result_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        wb_en, mem_r_en, ready, sram_we_n, sram_oe_n;
  logic [31:0] alu_result, mem_data;
  logic [3:0]  dest;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(2),
    .SRAM_AW    (18)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .alu_result_in(alu_result_in),
    .val_rm_in    (val_rm_in),
    .dest_in      (dest_in),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .alu_result   (alu_result),
    .dest         (dest),
    .mem_data     (mem_data),
    .ready        (ready),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_we_n    (sram_we_n),
    .sram_oe_n    (sram_oe_n)
  );

  // Small SRAM model: writes on the clock while we_n is low, reads asynchronously.
  logic [15:0] sram [0:15];
  always @(posedge clk) if (!sram_we_n) sram[sram_addr[3:0]] <= sram_wdata;
  assign sram_rdata = !sram_oe_n ? sram[sram_addr[3:0]] : 16'h0000;

  typedef struct {
    logic        rdy;
    logic        we_n;
    logic        oe_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [31:0] md;
    logic        wb;
    logic        mr;
    logic [3:0]  dst;
    logic [31:0] alu;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Expectation for one cycle; pass-through fields mirror what was driven.
  task automatic push(input string tag, input logic rdy, we_n, oe_n,
                      input logic [17:0] addr, input logic [15:0] wdata,
                      input logic [31:0] md);
    exp_t e;
    e.tag = tag; e.rdy = rdy; e.we_n = we_n; e.oe_n = oe_n;
    e.addr = addr; e.wdata = wdata; e.md = md;
    e.wb = wb_en_in; e.mr = mem_r_en_in; e.dst = dest_in; e.alu = alu_result_in;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (ready !== e.rdy || sram_we_n !== e.we_n || sram_oe_n !== e.oe_n ||
          sram_addr !== e.addr || sram_wdata !== e.wdata || mem_data !== e.md ||
          wb_en !== e.wb || mem_r_en !== e.mr || dest !== e.dst || alu_result !== e.alu) begin
        n_fail++;
        $display("FAIL %s @%0t: got rdy=%b we_n=%b oe_n=%b addr=%0h wd=%h md=%h wb=%b mr=%b dst=%0d alu=%h; want rdy=%b we_n=%b oe_n=%b addr=%0h wd=%h md=%h wb=%b mr=%b dst=%0d alu=%h",
                 e.tag, $time, ready, sram_we_n, sram_oe_n, sram_addr, sram_wdata, mem_data,
                 wb_en, mem_r_en, dest, alu_result, e.rdy, e.we_n, e.oe_n, e.addr, e.wdata,
                 e.md, e.wb, e.mr, e.dst, e.alu);
      end
    end
  end

  task automatic drive(input logic wb, rd, wr, input logic [31:0] a, v, input logic [3:0] d);
    wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
    alu_result_in = a; val_rm_in = v; dest_in = d;
  endtask

  // Issue one memory op (called just after a rising edge) and queue its 6 cycles.
  // md1 is the value visible during the high-half read, md2 in the done cycle.
  task automatic mem_op(input string tag, input logic rd, wr, input logic [31:0] a, v,
                        input logic [17:0] alo, input logic [31:0] md0, md1, md2);
    drive(1'b0, rd, wr, a, v, 4'd0);
    push({tag, ":req"}, 1'b0, 1'b1, 1'b1, 18'd0, 16'h0, md0);
    if (wr) begin
      repeat (2) push({tag, ":wr_lo"}, 1'b0, 1'b0, 1'b1, alo, v[15:0], md0);
      repeat (2) push({tag, ":wr_hi"}, 1'b0, 1'b0, 1'b1, alo + 18'd1, v[31:16], md0);
    end else begin
      repeat (2) push({tag, ":rd_lo"}, 1'b0, 1'b1, 1'b0, alo, 16'h0, md0);
      repeat (2) push({tag, ":rd_hi"}, 1'b0, 1'b1, 1'b0, alo + 18'd1, 16'h0, md1);
    end
    push({tag, ":done"}, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0, md2);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    push("reset", 1'b1, 1'b1, 1'b1, 18'd0, 16'h0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    mem_op("store", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0, 32'h0, 32'h0);
    mem_op("load", 1'b1, 1'b0, 32'd1028, 32'h0, 18'd2,
           32'h0, 32'h0000BEEF, 32'hDEADBEEF);
    // Back-to-back: inputs change on the edge ending each done cycle.
    mem_op("b2b_st", 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4,
           32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    mem_op("b2b_ld", 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4,
           32'hDEADBEEF, 32'hDEADF00D, 32'hCAFEF00D);
    mem_op("both_en", 1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0,
           32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

    // Non-memory instruction flows through with ready held high.
    drive(1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 4'd5);
    repeat (3) push("non_mem", 1'b1, 1'b1, 1'b1, 18'd0, 16'h0, 32'hCAFEF00D);
    repeat (3) @(posedge clk);
    #1;

    // Both-enables store must have landed at locations 0/1: read them back.
    mem_op("ld_base", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0,
           32'hCAFEF00D, 32'hCAFE5678, 32'h12345678);

    // Async reset in the middle of the high-half read.
    drive(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd0);
    push("rst_mid:req", 1'b0, 1'b1, 1'b1, 18'd0, 16'h0, 32'h12345678);
    repeat (2) push("rst_mid:rd_lo", 1'b0, 1'b1, 1'b0, 18'd2, 16'h0, 32'h12345678);
    push("rst_mid:async", 1'b0, 1'b1, 1'b1, 18'd0, 16'h0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst = 1'b1;
    push("post_rst_idle", 1'b1, 1'b1, 1'b1, 18'd0, 16'h0, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
